spi_reg_bridge: RTL

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

---
 rtl/spi_reg_bridge.sv | 105 ++++++++++
 1 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: turns SPI slave byte frames into register bus reads and bursted writes
module spi_reg_bridge #(
  parameter int WR_BURST_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       cs_idle,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       frame_done,
  output logic [4:0] frame_bytes,
  output logic       err_ovf
);
  localparam logic [2:0] WAIT_IDLE = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] CMD       = 3'd2;
  localparam logic [2:0] WRITE     = 3'd3;
  localparam logic [2:0] DISCARD   = 3'd4;
  localparam logic [4:0] BMAX = WR_BURST_MAX[4:0];
  logic [2:0] state;
  logic       cs_q;
  logic       rd_p;
  logic [6:0] addr;
  logic [4:0] wr_cnt;
  logic [4:0] cnt;
  logic       frame_start;
  logic       frame_end;
  logic       in_frame;
  logic [4:0] cnt_nx;
  always_comb begin
    frame_start = cs_q & ~cs_idle;
    frame_end   = ~cs_q & cs_idle;
    in_frame    = (state == CMD) || (state == WRITE) || (state == DISCARD);
    cnt_nx      = (rx_valid && cnt != 5'd31) ? cnt + 5'd1 : cnt;
  end
  // A byte landing on the frame-end edge is handled by its state before the return to IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= WAIT_IDLE;
      cs_q        <= 1'b0;
      rd_p        <= 1'b0;
      addr        <= '0;
      wr_cnt      <= '0;
      cnt         <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      frame_done  <= 1'b0;
      frame_bytes <= '0;
      err_ovf     <= 1'b0;
    end else begin
      cs_q       <= cs_idle;
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
      err_ovf    <= 1'b0;
      frame_done <= 1'b0;
      rd_p       <= reg_re;
      tx_valid   <= rd_p;
      if (rd_p) tx_data <= reg_rdata;
      if (in_frame) cnt <= cnt_nx;
      if (state == WAIT_IDLE && cs_idle) state <= IDLE;
      if (state == IDLE && frame_start) begin
        state <= CMD;
        cnt   <= '0;
      end
      if (state == CMD && rx_valid) begin
        if (rx_data[7]) begin
          state  <= WRITE;
          addr   <= rx_data[6:0];
          wr_cnt <= '0;
        end else begin
          state    <= DISCARD;
          reg_re   <= 1'b1;
          reg_addr <= rx_data[6:0];
        end
      end
      if (state == WRITE && rx_valid) begin
        if (wr_cnt < BMAX) begin
          reg_we    <= 1'b1;
          reg_addr  <= addr;
          reg_wdata <= rx_data;
          addr      <= addr + 7'd1;
          wr_cnt    <= wr_cnt + 5'd1;
        end else begin
          err_ovf <= 1'b1;
        end
      end
      if (in_frame && frame_end) begin
        state       <= IDLE;
        frame_done  <= 1'b1;
        frame_bytes <= cnt_nx;
      end
    end
  end
endmodule
